// File: rtl/axi_lite_req_arbiter.sv
// rtl/axi_lite_req_arbiter.sv - arbiter sharing one AXI4-Lite master among NUM_REQ requesters
// Define ARB_ROUND_ROBIN_EN for round-robin grants; otherwise fixed priority (lowest index wins).
module axi_lite_req_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         m_wr_req,
  output logic                         m_rd_req,
  output logic [ADDR_WIDTH-1:0]        m_wr_addr,
  output logic [ADDR_WIDTH-1:0]        m_rd_addr,
  output logic [DATA_WIDTH-1:0]        m_wr_data,
  output logic [STRB_W-1:0]            m_wr_strb,
  input  logic                         m_wr_done,
  input  logic                         m_rd_done,
  input  logic [1:0]                   m_wr_resp,
  input  logic [DATA_WIDTH-1:0]        m_rd_data,
  input  logic [1:0]                   m_rd_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] grant_idx;
  logic             op_write;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W:0]   cand;

  // Search begins just after the previous winner so a re-requesting winner goes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (state == RESP) begin
      last_grant <= grant_idx;
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    m_wr_req  = 1'b0;
    m_rd_req  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        req_ready[grant_idx] = 1'b1;
        m_wr_req             = op_write;
        m_rd_req             = !op_write;
        state_nxt            = WAIT;
      end
      WAIT: begin
        // A done of the opposite type belongs to nobody and is dropped.
        if (op_write ? m_wr_done : m_rd_done) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant_idx] = 1'b1;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Master-side fields only load for their own op type, so they hold across the other type.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_idx <= '0;
      op_write  <= 1'b0;
      m_wr_addr <= '0;
      m_wr_data <= '0;
      m_wr_strb <= '0;
      m_rd_addr <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        grant_idx <= win_idx;
        op_write  <= req_write[win_idx];
        if (req_write[win_idx]) begin
          m_wr_addr <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          m_wr_data <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          m_wr_strb <= req_wstrb[int'(win_idx)*STRB_W +: STRB_W];
        end else begin
          m_rd_addr <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      if (state == WAIT) begin
        if (op_write && m_wr_done) begin
          rsp_resp <= m_wr_resp;
        end else if (!op_write && m_rd_done) begin
          rsp_resp  <= m_rd_resp;
          rsp_rdata <= m_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// tb/tb_axi_lite_req_arbiter.sv - randomized self-checking bench for axi_lite_req_arbiter
module tb_axi_lite_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ*SW-1:0] req_wstrb;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  m_wr_req;
  logic                  m_rd_req;
  logic [AW-1:0]         m_wr_addr;
  logic [AW-1:0]         m_rd_addr;
  logic [DW-1:0]         m_wr_data;
  logic [SW-1:0]         m_wr_strb;
  logic                  m_wr_done;
  logic                  m_rd_done;
  logic [1:0]            m_wr_resp;
  logic [DW-1:0]         m_rd_data;
  logic [1:0]            m_rd_resp;

  axi_lite_req_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_resp (rsp_resp),
    .m_wr_req (m_wr_req),
    .m_rd_req (m_rd_req),
    .m_wr_addr(m_wr_addr),
    .m_rd_addr(m_rd_addr),
    .m_wr_data(m_wr_data),
    .m_wr_strb(m_wr_strb),
    .m_wr_done(m_wr_done),
    .m_rd_done(m_rd_done),
    .m_wr_resp(m_wr_resp),
    .m_rd_data(m_rd_data),
    .m_rd_resp(m_rd_resp)
  );

  always #5 aclk = ~aclk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            exp_last;
  int            last_win;
  int            reassert_mode;
  bit            rand_add;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] exp_wr_addr;
  logic [AW-1:0] exp_rd_addr;
  logic [DW-1:0] exp_wr_data;
  logic [SW-1:0] exp_wr_strb;
  int            exp_order[5];
  int            exp_t4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference winner: next pending index after the last one served, or lowest pending index.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i]           = 1'b1;
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_wstrb[i*SW +: SW]  = s;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom));
  endtask

  task automatic maybe_add();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] && $urandom_range(0, 3) == 0) rand_req(i);
    end
  endtask

  task automatic check_hold();
    check("hold_wr_addr", m_wr_addr, exp_wr_addr);
    check("hold_wr_data", m_wr_data, exp_wr_data);
    check("hold_wr_strb", m_wr_strb, exp_wr_strb);
    check("hold_rd_addr", m_rd_addr, exp_rd_addr);
  endtask

  // One full transaction: accept, master latency (optional wrong-type done), completion.
  task automatic run_txn(input bit spur, input logic [1:0] resp, input logic [DW-1:0] rd);
    int                 n;
    int                 win;
    int                 lat;
    bit                 w;
    logic [NUM_REQ-1:0] oh;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      if (n > 0) check("rsp_pulse_width", rsp_valid, '0);
      if (rand_add) maybe_add();
      if (req_valid == '0) rand_req(int'($urandom_range(0, NUM_REQ - 1)));
      tick();
      n++;
    end
    check("ready_seen", req_ready != '0, 1);
    if (req_ready == '0) return;
    win = model_pick(req_valid, exp_last);
    check("winner_exists", win >= 0, 1);
    if (win < 0) return;
    oh = NUM_REQ'(1) << win;
    w  = req_write[win];
    check("req_ready", req_ready, oh);
    check("m_wr_req", m_wr_req, w);
    check("m_rd_req", m_rd_req, !w);
    if (w) begin
      exp_wr_addr = req_addr[win*AW +: AW];
      exp_wr_data = req_wdata[win*DW +: DW];
      exp_wr_strb = req_wstrb[win*SW +: SW];
    end else begin
      exp_rd_addr = req_addr[win*AW +: AW];
    end
    check_hold();
    last_win       = win;
    req_valid[win] = 1'b0;
    if (reassert_mode == 1 || (reassert_mode == 2 && $urandom_range(0, 1) == 1)) rand_req(win);
    tick();
    lat = int'($urandom_range(0, 4));
    if (spur && lat == 0) lat = 1;
    for (int k = 0; k < lat; k++) begin
      check("rsp_early", rsp_valid, '0);
      check("ready_pulse_width", req_ready, '0);
      check("m_req_pulse_width", {m_wr_req, m_rd_req}, 2'b00);
      check_hold();
      if (spur && k == 0) begin
        if (w) begin
          m_rd_done = 1'b1;
          m_rd_resp = 2'($urandom);
          m_rd_data = $urandom;
        end else begin
          m_wr_done = 1'b1;
          m_wr_resp = 2'($urandom);
        end
      end
      if (rand_add) maybe_add();
      tick();
      m_wr_done = 1'b0;
      m_rd_done = 1'b0;
    end
    if (w) begin
      m_wr_done = 1'b1;
      m_wr_resp = resp;
      m_rd_data = $urandom;
      m_rd_resp = 2'($urandom);
    end else begin
      m_rd_done = 1'b1;
      m_rd_resp = resp;
      m_rd_data = rd;
      exp_rdata = rd;
    end
    tick();
    m_wr_done = 1'b0;
    m_rd_done = 1'b0;
    check("rsp_valid", rsp_valid, oh);
    check("rsp_resp", rsp_resp, resp);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    exp_last = win;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * NUM_REQ && req_valid != '0; k++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom), $urandom);
    end
    check("drained", req_valid, '0);
  endtask

  initial begin
    int n;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
    exp_t4    = 3;
`else
    exp_order = '{0, 0, 0, 0, 0};
    exp_t4    = 1;
`endif
    aresetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_wr_done = 1'b0; m_rd_done = 1'b0; m_wr_resp = '0; m_rd_resp = '0; m_rd_data = '0;
    rand_add = 1'b0; reassert_mode = 0; last_win = -1;
    exp_last = NUM_REQ - 1; exp_rdata = '0;
    exp_wr_addr = '0; exp_rd_addr = '0; exp_wr_data = '0; exp_wr_strb = '0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_m_req", {m_wr_req, m_rd_req}, 2'b00);
    check("rst_rsp", {rsp_rdata, rsp_resp}, '0);
    check_hold();
    aresetn = 1'b1;
    tick();

    set_req(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_txn(1'b0, 2'b00, '0);
    check("t1_winner", last_win, 2);
    check("t1_rsp_valid", rsp_valid, 4'b0100);
    check("t1_rsp_resp", rsp_resp, 2'b00);
    check("t1_wr_addr", m_wr_addr, 32'h10);
    check("t1_wr_data", m_wr_data, 32'hDEADBEEF);

    set_req(0, 1'b0, 32'h20, '0, '0);
    run_txn(1'b0, 2'b10, 32'hA5A5A5A5);
    check("t2_rsp_valid", rsp_valid, 4'b0001);
    check("t2_rsp_rdata", rsp_rdata, 32'hA5A5A5A5);
    check("t2_rsp_resp", rsp_resp, 2'b10);
    check("t2_wr_hold", m_wr_addr, 32'h10);

    // Reset while the master is still working drops the transaction on the floor.
    set_req(1, 1'b1, 32'h40, 32'h1234, 4'h3);
    n = 0;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check("t6_ready", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    tick();
    tick();
    aresetn = 1'b0;
    #1;
    check("t6_req_ready", req_ready, '0);
    check("t6_rsp_valid", rsp_valid, '0);
    check("t6_m_req", {m_wr_req, m_rd_req}, 2'b00);
    check("t6_rsp_rdata", rsp_rdata, '0);
    check("t6_wr_addr", m_wr_addr, '0);
    exp_last = NUM_REQ - 1; exp_rdata = '0;
    exp_wr_addr = '0; exp_rd_addr = '0; exp_wr_data = '0; exp_wr_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) rand_req(i);
    tick();
    tick();
    aresetn = 1'b1;

    reassert_mode = 1;
    for (int k = 0; k < 5; k++) begin
      run_txn(1'b0, 2'($urandom), $urandom);
      check("t3_order", last_win, exp_order[k]);
    end
    reassert_mode = 0;
    drain();

    rand_req(1);
    rand_req(3);
    reassert_mode = 1;
    run_txn(1'b0, 2'b00, $urandom);
    check("t4_first", last_win, 1);
    reassert_mode = 0;
    run_txn(1'b0, 2'b00, $urandom);
    check("t4_next", last_win, exp_t4);
    drain();

    set_req(2, 1'b1, 32'h80, 32'hCAFEF00D, 4'h5);
    run_txn(1'b1, 2'b01, '0);
    check("t5_rsp_valid", rsp_valid, 4'b0100);
    check("t5_rsp_resp", rsp_resp, 2'b01);

    rand_add = 1'b1;
    reassert_mode = 2;
    for (int k = 0; k < 200; k++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom), $urandom);
    end
    rand_add = 1'b0;
    reassert_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
